seq_det_ctrl: RTL and testbench
===============================

SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 SHALL have parameters: MAX_LEN, 8, maximum pattern length in bits; CNT_W, 8, match counter width.
REQ-002 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-003 rstn  in  1  reset, asynchronous and active-low.
REQ-004 cfg_we  in  1  pattern/config write strobe.
REQ-005 cfg_pat  in  MAX_LEN  pattern; cfg_pat[L-1] is the first serial bit, cfg_pat[0] the last.
REQ-006 cfg_len  in  3  pattern length minus one (L = cfg_len+1, range 1..8).
REQ-007 cfg_ovl  in  1  1 = overlapping detection, 0 = non-overlapping.
REQ-008 cfg_target  in  CNT_W  match count that ends a run; 0 = free-run.
REQ-009 start  in  1  begin a run; abort  in  1  end a run immediately.
REQ-010 in_valid  in  1  qualifies serial bit; in  in  1  serial data bit.
REQ-011 out  out  1  one-cycle match pulse; busy  out  1  run active; done  out  1  target reached.
REQ-012 match_cnt  out  CNT_W  matches in current/last run.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE when match_cnt reaches nonzero cfg_target; RUN->IDLE on abort; DONE->RUN on start; DONE->IDLE on abort.
REQ-014 SHALL latch cfg_pat/cfg_len/cfg_ovl/cfg_target on cfg_we only in IDLE or DONE; cfg_we in RUN ignored.
REQ-015 SHALL, on start, clear match_cnt, bit history and bits-seen counter; start in RUN ignored.
REQ-016 SHALL, in RUN with in_valid=1, shift in into history and increment bits-seen (saturating at L); in_valid=0 freezes all state.
REQ-017 SHALL detect a match when bits-seen (including current bit) >= L and last L bits equal cfg_pat[L-1:0].
REQ-018 SHALL assert out for exactly one cycle, registered, in the cycle after the clock edge sampling the completing bit.
REQ-019 SHALL, in non-overlapping mode, reset bits-seen to 0 on match; in overlapping mode keep history so suffix bits count toward next match.
REQ-020 SHALL increment match_cnt per match, saturating at 2^CNT_W-1 in free-run.
REQ-021 SHALL, on target match, pulse out, assert done from next cycle until start or abort, deassert busy, and ignore further in.
REQ-022 busy SHALL equal (state==RUN); done SHALL equal (state==DONE).
REQ-023 abort SHALL take priority over start and in_valid in the same cycle; no out pulse from a bit sampled with abort.
REQ-024 match_cnt SHALL hold its value in IDLE after abort and in DONE.

Reset
REQ-025 rstn low SHALL asynchronously force state IDLE, out=0, busy=0, done=0, match_cnt=0, history=0, bits-seen=0, cfg_pat=0, cfg_len=0, cfg_ovl=0, cfg_target=0.
REQ-026 Reset mid-run SHALL discard partial history; first match after reset needs a full L fresh bits after start.

Configuration
REQ-027 Macro SEQ_DET_OVERLAP_EN: defined -> cfg_ovl honored per REQ-019; undefined -> cfg_ovl port present but ignored, detection always non-overlapping.

Structure
REQ-028 Package seq_det_pkg SHALL hold state enum (IDLE/RUN/DONE), MAX_LEN and CNT_W defaults.
REQ-029 Sub-module seq_det_core SHALL hold history shift register, bits-seen counter and compare; seq_det_ctrl holds FSM, config regs, counter.

Verification
REQ-030 pat=101, L=3, ovl=0, target=0; stream 1,0,1,0,1 -> one out pulse after 3rd bit, match_cnt=1.
REQ-031 Same stream with ovl=1 and SEQ_DET_OVERLAP_EN defined -> pulses after 3rd and 5th bits, match_cnt=2; undefined -> match_cnt=1.
REQ-032 pat=110, L=3, target=2; stream 1,1,0,1,1,0,1,1,0 -> done after 6th bit, busy=0, 9th bit gives no pulse, match_cnt=2.
REQ-033 in_valid=0 gaps between bits of 1,0,1 -> still one match; cfg_we during RUN -> pattern unchanged.
REQ-034 abort and completing bit in same cycle -> no out pulse, state IDLE, match_cnt unchanged.
REQ-035 rstn low asynchronously mid-run (between edges) -> all outputs 0 immediately; pat=1, L=1, 300 ones in free-run -> match_cnt saturates at 255.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and default sizing for the serial pattern detector.
package seq_det_pkg;

   localparam int MAX_LEN_DEF = 8;
   localparam int CNT_W_DEF   = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_det_core.sv
// Bit history, bits-seen counter and pattern compare; hit is combinational on the current bit.
// No backpressure: shifts whenever shift is high, clr wins over shift.
module seq_det_core
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = MAX_LEN_DEF
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       clr,
   input  logic                       shift,
   input  logic                       din,
   input  logic [MAX_LEN-1:0]         pat,
   input  logic [$clog2(MAX_LEN)-1:0] len,
   input  logic                       ovl,
   output logic                       hit
);

   localparam int SW = $clog2(MAX_LEN + 1);

   logic [MAX_LEN-1:0] hist;
   logic [MAX_LEN-1:0] hist_nxt;
   logic [MAX_LEN-1:0] mask;
   logic [SW-1:0]      seen;
   logic [SW-1:0]      seen_inc;
   logic [SW-1:0]      plen;

   assign plen     = SW'(len) + SW'(1);
   assign seen_inc = seen + SW'(1);
   assign hist_nxt = {hist[MAX_LEN-2:0], din};

   always_comb begin
      mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         mask[i] = (i < int'(plen));
      end
   end

   // seen_inc counts the bit being sampled this cycle.
   assign hit = shift && (seen_inc >= plen) && (((hist_nxt ^ pat) & mask) == '0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hist <= '0;
         seen <= '0;
      end else if (clr) begin
         hist <= '0;
         seen <= '0;
      end else if (shift) begin
         hist <= hist_nxt;
         if (hit && !ovl)
            seen <= '0;
         else if (seen_inc > plen)
            seen <= plen;
         else
            seen <= seen_inc;
      end
   end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run-controlled serial pattern detector: out pulses one cycle after the completing bit's edge.
// No backpressure; in_valid=0 freezes detection. SEQ_DET_OVERLAP_EN enables overlapping matches.
module seq_det_ctrl
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = MAX_LEN_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       cfg_we,
   input  logic [MAX_LEN-1:0]         cfg_pat,
   input  logic [$clog2(MAX_LEN)-1:0] cfg_len,
   input  logic                       cfg_ovl,
   input  logic [CNT_W-1:0]           cfg_target,
   input  logic                       start,
   input  logic                       abort,
   input  logic                       in_valid,
   input  logic                       in,
   output logic                       out,
   output logic                       busy,
   output logic                       done,
   output logic [CNT_W-1:0]           match_cnt
);

   localparam int LW = $clog2(MAX_LEN);

   state_t             state;
   state_t             state_nxt;
   logic [MAX_LEN-1:0] pat_q;
   logic [LW-1:0]      len_q;
   logic               ovl_q;
   logic               ovl_eff;
   logic [CNT_W-1:0]   target_q;
   logic [CNT_W-1:0]   cnt_nxt;
   logic [CNT_W-1:0]   cnt_inc;
   logic               out_nxt;
   logic               idle_or_done;
   logic               clr;
   logic               shift;
   logic               hit;

   assign idle_or_done = (state != RUN);
   assign clr          = idle_or_done && start && !abort;
   assign shift        = (state == RUN) && in_valid && !abort;
   assign cnt_inc      = (match_cnt == {CNT_W{1'b1}}) ? match_cnt : match_cnt + CNT_W'(1);

`ifdef SEQ_DET_OVERLAP_EN
   assign ovl_eff = ovl_q;
`else
   assign ovl_eff = ovl_q & 1'b0;
`endif

   // Configuration is frozen while a run is active.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pat_q    <= '0;
         len_q    <= '0;
         ovl_q    <= 1'b0;
         target_q <= '0;
      end else if (idle_or_done && cfg_we) begin
         pat_q    <= cfg_pat;
         len_q    <= cfg_len;
         ovl_q    <= cfg_ovl;
         target_q <= cfg_target;
      end
   end

   seq_det_core #(
      .MAX_LEN (MAX_LEN)
   ) u_core (
      .clk   (clk),
      .rstn  (rstn),
      .clr   (clr),
      .shift (shift),
      .din   (in),
      .pat   (pat_q),
      .len   (len_q),
      .ovl   (ovl_eff),
      .hit   (hit)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = match_cnt;
      out_nxt   = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (start) begin
               state_nxt = RUN;
               cnt_nxt   = '0;
            end
         end
         RUN: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (hit) begin
               out_nxt = 1'b1;
               cnt_nxt = cnt_inc;
               if ((target_q != '0) && (cnt_inc == target_q))
                  state_nxt = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         match_cnt <= '0;
         out       <= 1'b0;
      end else begin
         state     <= state_nxt;
         match_cnt <= cnt_nxt;
         out       <= out_nxt;
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed literal checks.
module tb_seq_det_ctrl;

`ifdef SEQ_DET_OVERLAP_EN
   localparam bit OVL_EN = 1'b1;
`else
   localparam bit OVL_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rstn;
   logic       cfg_we;
   logic [7:0] cfg_pat;
   logic [2:0] cfg_len;
   logic       cfg_ovl;
   logic [7:0] cfg_target;
   logic       start;
   logic       abort;
   logic       in_valid;
   logic       in;
   logic       out;
   logic       busy;
   logic       done;
   logic [7:0] match_cnt;

   int vectors     = 0;
   int miscompares = 0;
   int pulses      = 0;

   seq_det_ctrl dut (
      .clk        (clk),
      .rstn       (rstn),
      .cfg_we     (cfg_we),
      .cfg_pat    (cfg_pat),
      .cfg_len    (cfg_len),
      .cfg_ovl    (cfg_ovl),
      .cfg_target (cfg_target),
      .start      (start),
      .abort      (abort),
      .in_valid   (in_valid),
      .in         (in),
      .out        (out),
      .busy       (busy),
      .done       (done),
      .match_cnt  (match_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: 0 idle, 1 running, 2 finished; mq holds bits usable toward the next match.
   int         mst     = 0;
   int         mcnt    = 0;
   bit         exp_out = 1'b0;
   bit         mq[$];
   logic [7:0] m_pat   = '0;
   int         m_len   = 1;
   bit         m_ovl   = 1'b0;
   int         m_tgt   = 0;

   always @(posedge clk or negedge rstn) begin : model
      bit ok;
      if (!rstn) begin
         mst = 0; mcnt = 0; exp_out = 1'b0; mq.delete();
         m_pat = '0; m_len = 1; m_ovl = 1'b0; m_tgt = 0;
      end else begin
         exp_out = 1'b0;
         if (mst != 1 && cfg_we) begin
            m_pat = cfg_pat; m_len = cfg_len + 1; m_ovl = cfg_ovl; m_tgt = cfg_target;
         end
         if (abort) begin
            mst = 0;
         end else if (mst != 1) begin
            if (start) begin
               mst = 1; mcnt = 0; mq.delete();
            end
         end else if (in_valid) begin
            mq.push_back(in);
            if (mq.size() > 8) void'(mq.pop_front());
            ok = (mq.size() >= m_len);
            if (ok)
               for (int k = 0; k < m_len; k++)
                  if (mq[mq.size() - 1 - k] != m_pat[k]) ok = 1'b0;
            if (ok) begin
               exp_out = 1'b1;
               if (mcnt < 255) mcnt++;
               if (!(OVL_EN && m_ovl)) mq.delete();
               if (m_tgt != 0 && mcnt == m_tgt) mst = 2;
            end
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("out", {31'd0, out}, {31'd0, exp_out});
      check("busy", {31'd0, busy}, (mst == 1) ? 32'd1 : 32'd0);
      check("done", {31'd0, done}, (mst == 2) ? 32'd1 : 32'd0);
      check("match_cnt", {24'd0, match_cnt}, mcnt);
      if (out === 1'b1) pulses++;
   end

   task automatic apply(input logic we, input logic st, input logic ab, input logic iv, input logic b);
      @(posedge clk);
      #1;
      cfg_we = we; start = st; abort = ab; in_valid = iv; in = b;
   endtask

   task automatic idle(input int n);
      repeat (n) apply(0, 0, 0, 0, 0);
   endtask

   task automatic setcfg(input logic [7:0] p, input logic [2:0] l, input logic o, input logic [7:0] t);
      cfg_pat = p; cfg_len = l; cfg_ovl = o; cfg_target = t;
      apply(1, 0, 0, 0, 0);
   endtask

   task automatic feed(input logic [8:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) apply(0, 0, 0, 1, bits[i]);
   endtask

   initial begin
      rstn = 1'b0; cfg_we = 0; cfg_pat = '0; cfg_len = '0; cfg_ovl = 0; cfg_target = '0;
      start = 0; abort = 0; in_valid = 0; in = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", {31'd0, busy}, 0);
      check("reset_done", {31'd0, done}, 0);
      check("reset_cnt", {24'd0, match_cnt}, 0);
      rstn = 1'b1;

      // 101, non-overlapping, free-run
      setcfg(8'b101, 3'd2, 1'b0, 8'd0);
      apply(0, 1, 0, 0, 0);
      pulses = 0;
      feed(9'b10101, 5);
      idle(3);
      check("nonovl_cnt", {24'd0, match_cnt}, 1);
      check("nonovl_pulses", pulses, 1);

      // same stream, overlap requested
      apply(0, 0, 1, 0, 0);
      setcfg(8'b101, 3'd2, 1'b1, 8'd0);
      apply(0, 1, 0, 0, 0);
      pulses = 0;
      feed(9'b10101, 5);
      idle(3);
      check("ovl_cnt", {24'd0, match_cnt}, OVL_EN ? 2 : 1);
      check("ovl_pulses", pulses, OVL_EN ? 2 : 1);

      // gaps in in_valid and a config write during the run
      apply(0, 0, 1, 0, 0);
      setcfg(8'b101, 3'd2, 1'b0, 8'd0);
      apply(0, 1, 0, 0, 0);
      pulses = 0;
      cfg_pat = 8'b111; cfg_len = 3'd2;
      apply(1, 0, 0, 0, 0);
      apply(0, 0, 0, 1, 1); idle(2);
      apply(0, 0, 0, 1, 0); idle(1);
      apply(0, 0, 0, 1, 1);
      idle(3);
      check("gap_cnt", {24'd0, match_cnt}, 1);
      check("gap_pulses", pulses, 1);

      // target of two matches
      apply(0, 0, 1, 0, 0);
      setcfg(8'b110, 3'd2, 1'b0, 8'd2);
      apply(0, 1, 0, 0, 0);
      pulses = 0;
      feed(9'b110110110, 9);
      idle(3);
      check("target_done", {31'd0, done}, 1);
      check("target_busy", {31'd0, busy}, 0);
      check("target_cnt", {24'd0, match_cnt}, 2);
      check("target_pulses", pulses, 2);

      // abort coincides with a completing bit
      apply(0, 0, 1, 0, 0);
      setcfg(8'b101, 3'd2, 1'b0, 8'd0);
      apply(0, 1, 0, 0, 0);
      pulses = 0;
      feed(9'b10110, 5);
      apply(0, 0, 1, 1, 1);
      idle(3);
      check("abort_pulses", pulses, 1);
      check("abort_cnt", {24'd0, match_cnt}, 1);
      check("abort_busy", {31'd0, busy}, 0);
      check("abort_done", {31'd0, done}, 0);

      // asynchronous reset while out is high
      apply(0, 1, 0, 0, 0);
      feed(9'b101, 3);
      @(posedge clk);
      #2;
      check("pre_reset_out", {31'd0, out}, 1);
      rstn = 1'b0;
      #1;
      check("async_out", {31'd0, out}, 0);
      check("async_busy", {31'd0, busy}, 0);
      check("async_done", {31'd0, done}, 0);
      check("async_cnt", {24'd0, match_cnt}, 0);
      idle(2);
      rstn = 1'b1;
      apply(0, 1, 0, 0, 0);
      feed(9'b0110, 4);
      idle(2);

      // saturation with single-bit pattern
      apply(0, 0, 1, 0, 0);
      setcfg(8'b1, 3'd0, 1'b0, 8'd0);
      apply(0, 1, 0, 0, 0);
      repeat (300) apply(0, 0, 0, 1, 1);
      idle(2);
      check("sat_cnt", {24'd0, match_cnt}, 255);
      check("sat_busy", {31'd0, busy}, 1);

      // random traffic
      apply(0, 0, 1, 0, 0);
      repeat (800) begin
         cfg_pat    = 8'($urandom);
         cfg_len    = 3'($urandom_range(0, 3));
         cfg_ovl    = 1'($urandom);
         cfg_target = 8'($urandom_range(0, 4));
         apply(($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
               ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7), 1'($urandom));
      end
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      miscompares++;
      $display("FAIL watchdog: time limit reached, got no finish, expected finish");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "watchdog");
   end

endmodule
